// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD host command path (serializer and deserializer).
// Holds response frame lengths, the default N_CR timeout, the CRC7 polynomial
// and the receive FSM state encoding.
package sd_cmd_pkg;

  localparam int unsigned R2_LEN         = 136;
  localparam int unsigned SHORT_RESP_LEN = 48;
  localparam int unsigned DEF_TIMEOUT    = 64;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRecv,
    StDone
  } cmd_rx_state_e;

endpackage

// File: rtl/cmd_deserializer_if.sv
// Bundle between the command controller (master) and the response deserializer
// (slave).
//   enable/long_resp/crc_chk : arm control and response type
//   in                       : serial CMD line (idles high)
//   out                      : received frame, right-aligned
//   valid/crc_err/frame_err  : completion pulse and its status flags
//   timeout/busy             : no-response pulse and receiver activity
interface cmd_deserializer_if
  import sd_cmd_pkg::*;
#(
  parameter int unsigned LONG_LEN = R2_LEN
);
  logic                enable;
  logic                long_resp;
  logic                crc_chk;
  logic                in;
  logic [LONG_LEN-1:0] out;
  logic                valid;
  logic                crc_err;
  logic                frame_err;
  logic                timeout;
  logic                busy;

  modport master (
    output enable, long_resp, crc_chk, in,
    input  out, valid, crc_err, frame_err, timeout, busy
  );

  modport slave (
    input  enable, long_resp, crc_chk, in,
    output out, valid, crc_err, frame_err, timeout, busy
  );
endinterface

// File: rtl/crc7.sv
// Serial bit-in CRC7 generator/checker, MSB first, register initialised to 0.
// Ports: clk, reset (sync active-low), clear (zero the register), en (absorb din),
//        din (serial data bit), crc (current remainder).
module crc7
  import sd_cmd_pkg::*;
#(
  parameter logic [6:0] POLY = CRC7_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = din ^ crc_q[6];
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? POLY : 7'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/cmd_deserializer.sv
// SD CMD-line response receiver. Waits for the start bit, shifts in a 48-bit or
// 136-bit (R2) response MSB-first and reports framing, CRC7 and timeout status.
// Ports: clk, reset (sync active-low), bus (cmd_deserializer_if.slave).
// Build option: define CMD_DESER_CRC_EN to instantiate the CRC7 checker; without
// it crc_err is tied 0 and crc_chk is ignored.
module cmd_deserializer
  import sd_cmd_pkg::*;
#(
  parameter int unsigned LONG_LEN  = R2_LEN,
  parameter int unsigned SHORT_LEN = SHORT_RESP_LEN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input logic                    clk,
  input logic                    reset,
  cmd_deserializer_if.slave      bus
);

  localparam int unsigned CntW = $clog2(LONG_LEN + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  cmd_rx_state_e       state_q, state_d;
  logic [LONG_LEN-1:0] out_q, out_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]       idle_cnt_q, idle_cnt_d;
  logic                long_q, long_d;
  logic                chk_q, chk_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;
  logic                frame_err_q, frame_err_d;
  logic                crc_err_q, crc_err_d;

  logic [CntW-1:0]     frame_len;
  logic [CntW-1:0]     cov_lo;
  logic                crc_clr;
  logic                crc_en;
  logic [6:0]          crc_val;

`ifdef CMD_DESER_CRC_EN
  crc7 #(
    .POLY (CRC7_POLY)
  ) u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clear (crc_clr),
    .en    (crc_en),
    .din   (bus.in),
    .crc   (crc_val)
  );
`else
  assign crc_val = '0;
  logic unused_crc;
  assign unused_crc = ^{crc_clr, crc_en, chk_q, crc_val};
`endif

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    long_d      = long_q;
    chk_d       = chk_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    frame_err_d = frame_err_q;
    crc_err_d   = crc_err_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;

    frame_len = long_q ? CntW'(LONG_LEN) : CntW'(SHORT_LEN);
    // R2 excludes its 8-bit header from CRC coverage; short frames cover from the start bit.
    cov_lo    = long_q ? CntW'(8) : '0;

    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d    = StWait;
          long_d     = bus.long_resp;
          chk_d      = bus.crc_chk;
          out_d      = '0;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          crc_clr    = 1'b1;
        end
      end
      StWait: begin
        if (!bus.enable) begin
          state_d = StIdle;
        end else if (!bus.in) begin
          state_d   = StRecv;
          out_d     = {out_q[LONG_LEN-2:0], bus.in};
          bit_cnt_d = CntW'(1);
          crc_en    = (cov_lo == '0);
        end else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
      end
      StRecv: begin
        if (!bus.enable) begin
          state_d = StIdle;
        end else begin
          out_d     = {out_q[LONG_LEN-2:0], bus.in};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          // bit_cnt_q is the index of the bit being taken, counted from the start bit.
          crc_en    = (bit_cnt_q >= cov_lo) && (bit_cnt_q < frame_len - CntW'(8));
          if (bit_cnt_q == frame_len - CntW'(1)) state_d = StDone;
        end
      end
      StDone: begin
        valid_d     = 1'b1;
        frame_err_d = out_q[frame_len - CntW'(2)] | ~out_q[0];
`ifdef CMD_DESER_CRC_EN
        crc_err_d   = chk_q && (crc_val != out_q[7:1]);
`else
        crc_err_d   = 1'b0;
`endif
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWait) || (state_d == StRecv);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      out_q       <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      long_q      <= 1'b0;
      chk_q       <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      long_q      <= long_d;
      chk_q       <= chk_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.crc_err   = crc_err_q;

endmodule

// File: tb/tb_cmd_deserializer.sv
// Directed bench for cmd_deserializer: frames are driven on the CMD line, their
// expected results queued, and a monitor pops and checks them on each valid pulse.
module tb_cmd_deserializer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cmd_deserializer_if ifc ();

  cmd_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {
    logic [135:0] out;
    logic         crc_err;
    logic         frame_err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;
  int   n_to = 0;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Scoreboard side: every valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (ifc.valid || ifc.timeout) check("valid_timeout_exclusive", ifc.valid & ifc.timeout, 0);
    if (ifc.timeout) n_to++;
    if (ifc.valid) begin
      exp_t e;
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out", ifc.out, e.out);
        check("crc_err", ifc.crc_err, e.crc_err);
        check("frame_err", ifc.frame_err, e.frame_err);
      end
    end
  end

  task automatic send_frame(input logic [135:0] f, input int n, input logic lr, input logic chk,
                            input int idles, input string tag);
    exp_t e;
    int   hi;
    hi = lr ? 127 : n - 1;
    e.out       = f;
    e.frame_err = f[n-2] | ~f[0];
`ifdef CMD_DESER_CRC_EN
    e.crc_err   = chk && (crc7_model(f, hi, 8) != f[7:1]);
`else
    e.crc_err   = 1'b0;
`endif
    sb.push_back(e);
    @(negedge clk);
    ifc.enable    = 1'b1;
    ifc.long_resp = lr;
    ifc.crc_chk   = chk;
    ifc.in        = 1'b1;
    @(negedge clk);
    check({tag, "_busy_armed"}, ifc.busy, 1);
    repeat (idles) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      ifc.in = f[i];
      @(negedge clk);
    end
    ifc.in = 1'b1;
    check({tag, "_valid_early"}, ifc.valid, 0);
    @(negedge clk);
    check({tag, "_valid_timing"}, ifc.valid, 1);
    ifc.enable = 1'b0;
    @(negedge clk);
    check({tag, "_valid_pulse"}, ifc.valid, 0);
    check({tag, "_busy_after"}, ifc.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] f;
    logic [135:0] r2;
    logic [127:0] rnd;

    reset = 1'b0;
    ifc.enable = 1'b0;
    ifc.long_resp = 1'b0;
    ifc.crc_chk = 1'b0;
    ifc.in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", ifc.out, 0);
    check("rst_valid", ifc.valid, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_timeout", ifc.timeout, 0);
    check("rst_flags", {ifc.crc_err, ifc.frame_err}, 0);
    reset = 1'b1;

    // R7 with good CRC, corrupted payload, and host-direction frame.
    send_frame(136'h08000001AA13, 48, 1'b0, 1'b1, 5, "r7");
    send_frame(136'h08000001AB13, 48, 1'b0, 1'b1, 5, "r7_bad");
    send_frame(136'h400000000095, 48, 1'b0, 1'b1, 3, "host");

    // No response: single timeout after 64 WAIT samples.
    @(negedge clk);
    ifc.enable = 1'b1;
    ifc.in = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 63) begin
        check("to_before", ifc.timeout, 0);
        check("to_busy_before", ifc.busy, 1);
      end
      if (c == 64) begin
        check("to_pulse", ifc.timeout, 1);
        check("to_busy_drop", ifc.busy, 0);
      end
      if (c == 65) check("to_one_cycle", ifc.timeout, 0);
    end
    ifc.enable = 1'b0;
    repeat (2) @(negedge clk);

    // R2 long frame with a model-computed CRC over bits [127:8].
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    r2 = '0;
    r2[135:128] = 8'h3F;
    r2[127:8] = rnd[119:0];
    r2[7:1] = crc7_model(r2, 127, 8);
    r2[0] = 1'b1;
    send_frame(r2, 136, 1'b1, 1'b1, 2, "r2");

    // Reset in the middle of an R1 reception, then a clean frame.
    f = 136'h08000001AA13;
    @(negedge clk);
    ifc.enable = 1'b1;
    ifc.long_resp = 1'b0;
    ifc.crc_chk = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    for (int i = 47; i > 27; i--) begin
      ifc.in = f[i];
      @(negedge clk);
    end
    check("mid_busy", ifc.busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out", ifc.out, 0);
    check("mid_rst_busy", ifc.busy, 0);
    check("mid_rst_flags", {ifc.valid, ifc.timeout, ifc.crc_err, ifc.frame_err}, 0);
    ifc.enable = 1'b0;
    ifc.in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_frame(136'h08000001AA13, 48, 1'b0, 1'b1, 5, "after_rst");

    repeat (3) @(negedge clk);
    check("valid_count", n_valid, 5);
    check("timeout_count", n_to, 1);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_deserializer.md
# cmd_deserializer

Receive-side counterpart of the command serializer in the SD host. Watches the card-driven CMD line, detects the response start bit, shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response MSB-first, and presents it in parallel. It also reports framing, CRC7 and no-response timeout status to the command controller.

## Interface
- `LONG_LEN`, 136: bit length of an R2 response and width of `out`.
- `SHORT_LEN`, 48: bit length of all other responses.
- `TIMEOUT`, 64: maximum idle cycles (N_CR) waited for a start bit.
- `clk`  in  1  sampling clock; CMD line sampled on rising edge.
- `reset`  in  1  synchronous, active-low; low on a rising edge resets the block.
- `enable`  in  1  arm and hold receiver; low aborts any reception.
- `long_resp`  in  1  1 = expect 136-bit R2; sampled when arming.
- `crc_chk`  in  1  1 = check CRC7 (low for R3); sampled when arming.
- `in`  in  1  serial CMD line, idles high.
- `out`  out  LONG_LEN  received frame, right-aligned; bits above frame length are 0.
- `valid`  out  1  one-cycle pulse: `out` and error flags are valid.
- `crc_err`  out  1  CRC7 mismatch; qualified by `valid`.
- `frame_err`  out  1  transmission bit ≠ 0 or end bit ≠ 1; qualified by `valid`.
- `timeout`  out  1  one-cycle pulse: no start bit within `TIMEOUT` cycles.
- `busy`  out  1  high in WAIT and RECV.

## Operation
- States: IDLE, WAIT, RECV, DONE.
- IDLE → WAIT when `enable`=1.
  - Latches `long_resp` and `crc_chk`.
  - Clears `out`, the bit counter, the idle counter and the CRC register.
- WAIT:
  - `in`=0 → RECV. This 0 is the start bit: shift it in, counter=1.
  - `in`=1 → idle counter +1. When the counter reaches `TIMEOUT` → IDLE with `timeout`=1 for one cycle.
- RECV:
  - Each cycle: `out <= {out[LONG_LEN-2:0], in}`, counter +1.
  - When the counter equals the frame length (SHORT_LEN or LONG_LEN), the bit just taken is the end bit → DONE.
- DONE (one cycle):
  - `valid`=1.
  - Flags are evaluated on the latched frame.
  - Next state is IDLE; re-arms on the following cycle if `enable` is still high.
- `enable`=0 in WAIT or RECV → IDLE next cycle. No `valid`, no `timeout`; `out` keeps the partial contents.
- `frame_err`: second received bit = 1, or last bit = 0.
- CRC7 (poly x^7+x^3+1, register init 0):
  - Coverage: bits [47:8] for short frames; bits [127:8] for R2, i.e. the 8-bit header is excluded.
  - Compared against frame bits [7:1].
  - `crc_err` is forced to 0 when `crc_chk` was 0.
- `out` holds its value after DONE until the next arming.

## Timing
- Reset values: `out`=0, `valid`=0, `crc_err`=0, `frame_err`=0, `timeout`=0, `busy`=0, state IDLE.
- Arming latency: `enable` high at edge k → WAIT after k. The first bit is sampled at edge k+1.
- Start bit sampled at edge s → end bit sampled at edge s+N−1 (N = frame length). `valid` is high during the cycle after edge s+N.
- Timeout: first WAIT sample at edge w. With `in` held high, `timeout` is high during the cycle after edge w+TIMEOUT−1.
- Reset low on any edge overrides all transitions, including mid-RECV and DONE.
- `valid` and `timeout` are never asserted in the same cycle.

## Configuration
- `CMD_DESER_CRC_EN` defined:
  - The CRC7 checker is instantiated.
  - `crc_err` behaves as above.
- `CMD_DESER_CRC_EN` undefined:
  - No CRC logic.
  - `crc_err` is tied 0.
  - `crc_chk` is ignored.
  - All other behaviour is unchanged.

## Structure
- Shared package `sd_cmd_pkg` holds:
  - the frame-length constants (48, 136) and the default timeout (64);
  - CRC7 polynomial 7'h09;
  - the state encoding for IDLE/WAIT/RECV/DONE.
- One sub-module, `crc7`:
  - serial bit-in CRC7 with `clear` and `en` inputs and a 7-bit output;
  - reused by the command serializer side.

## Test plan
- R7 frame 48'h08000001AA13, `crc_chk`=1, `long_resp`=0, preceded by 5 idle highs → `valid` pulse 48 cycles after the start bit; `out[47:0]`=48'h08000001AA13; `crc_err`=0; `frame_err`=0.
- Same frame with the payload corrupted to 48'h08000001AB13 → `valid`, `crc_err`=1, `frame_err`=0.
- Host-style frame 48'h400000000095 (transmission bit 1) → `valid`, `frame_err`=1, `crc_err`=0.
- `enable`=1 with `in` held high for 70 cycles → single `timeout` pulse after 64 WAIT samples; `valid` never asserted; `busy` drops with the pulse.
- R2 frame with `long_resp`=1 (bench CRC7 model over bits [127:8]) → `valid` 136 cycles after the start bit; `out` equals the full 136-bit frame.
- Reset low at bit 20 of an R1 reception, released, then a fresh frame 48'h08000001AA13 → all outputs 0 during reset; second frame received cleanly with no error flags.
